// File: rtl/fifo_read_ctrl_if.sv
// Read-side bundle between the pixel FIFO read controller, the FIFO memory,
// the write-domain pointer and the VGA pixel consumer.
interface fifo_read_ctrl_if #(
    parameter int DATA_WIDTH = 4,
    parameter int PTR_WIDTH  = 9,
    parameter int CNT_WIDTH  = 16
);
    logic [PTR_WIDTH:0]    g_wptr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [PTR_WIDTH:0]    b_rptr;
    logic [PTR_WIDTH:0]    g_rptr;
    logic                  empty;
    logic [PTR_WIDTH:0]    rd_level;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  flush;
    logic [CNT_WIDTH-1:0]  underflow_cnt;

    // The controller side.
    modport master (
        input  g_wptr, mem_data, pix_ready, flush,
        output b_rptr, g_rptr, empty, rd_level, pix_data, pix_valid, underflow_cnt
    );

    // Memory, write-pointer source and pixel consumer side.
    modport slave (
        output g_wptr, mem_data, pix_ready, flush,
        input  b_rptr, g_rptr, empty, rd_level, pix_data, pix_valid, underflow_cnt
    );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller of the camera-to-VGA pixel FIFO: pointer sync,
// empty/level, one-entry valid/ready output register, underflow count, flush.
module fifo_read_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int PTR_WIDTH  = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic             rclk,
    input  logic             rst,
    fifo_read_ctrl_if.master bus
);
    typedef logic [PTR_WIDTH:0]    ptr_t;
    typedef logic [CNT_WIDTH-1:0]  cnt_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_WIDTH] = g[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    ptr_t  wq1, wq2, wbin;
    ptr_t  b_rptr, g_rptr, b_rptr_nxt;
    data_t pix_data;
    logic  pix_valid;
    cnt_t  underflow_cnt;
    logic  empty, load, xfer, underflow;

    // Plain two-flop synchronizer; nothing may sit between the stages.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value, which is what makes wq2 lag wq1 by a cycle.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            wq1 <= '0;
            wq2 <= '0;
        end else begin
            wq1 <= bus.g_wptr;
            wq2 <= wq1;
        end
    end

    always_comb begin
        wbin       = gray2bin(wq2);
        b_rptr_nxt = b_rptr + ptr_t'(1);
    end

    assign empty     = (g_rptr == wq2);
    assign xfer      = pix_valid && bus.pix_ready;
    assign load      = !empty && (!pix_valid || bus.pix_ready) && !bus.flush;
    assign underflow = bus.pix_ready && !pix_valid;

    // Flush outranks load and transfer; g_rptr is always a flop output so the
    // write domain never sees a combinational glitch.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            b_rptr    <= '0;
            g_rptr    <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
        end else if (bus.flush) begin
            pix_valid <= 1'b0;
            b_rptr    <= wbin;
            g_rptr    <= wq2;
        end else if (load) begin
            pix_data  <= bus.mem_data;
            pix_valid <= 1'b1;
            b_rptr    <= b_rptr_nxt;
            g_rptr    <= bin2gray(b_rptr_nxt);
        end else if (xfer) begin
            pix_valid <= 1'b0;
        end
    end

    // Saturating; survives flush, cleared only by reset.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            underflow_cnt <= '0;
        end else if (underflow && (underflow_cnt != '1)) begin
            underflow_cnt <= underflow_cnt + cnt_t'(1);
        end
    end

    assign bus.b_rptr        = b_rptr;
    assign bus.g_rptr        = g_rptr;
    assign bus.empty         = empty;
    assign bus.rd_level      = wbin - b_rptr;
    assign bus.pix_data      = pix_data;
    assign bus.pix_valid     = pix_valid;
    assign bus.underflow_cnt = underflow_cnt;
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl: a queue of written pixels is compared
// against every handshake, and a pointer/level model is checked every cycle.
module tb_fifo_read_ctrl;
    localparam int DW = 4;
    localparam int PW = 9;
    localparam int CW = 16;

    logic rclk   = 1'b0;
    logic rst    = 1'b0;
    logic clk_en = 1'b0;

    fifo_read_ctrl_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

    fifo_read_ctrl #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .rclk (rclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 if (clk_en) rclk = ~rclk;

    // Reference state
    logic [DW-1:0] mem [512];
    logic [DW-1:0] sb [$];
    logic [9:0]    wr_ptr   = '0;
    logic [9:0]    wp_d1, wp_d2;
    logic [9:0]    rd_base  = '0;
    logic [9:0]    rd_exp   = '0;
    logic [9:0]    prev_b   = '0;
    logic [15:0]   uf_model = '0;
    int            n_xfer   = 0;
    logic          mon_en   = 1'b0;
    logic          saw_wrap = 1'b0;
    int            tests    = 0;
    int            failed   = 0;

    function automatic logic [9:0] bin2gray(input logic [9:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        mem[wr_ptr[8:0]] = d;
        sb.push_back(d);
        wr_ptr     = wr_ptr + 10'd1;
        bus.g_wptr = bin2gray(wr_ptr);
    endtask

    task automatic drain();
        bus.pix_ready = 1'b1;
        for (int i = 0; i < 2000 && sb.size() != 0; i++) begin
            @(posedge rclk);
            #1;
        end
        bus.pix_ready = 1'b0;
        check("drain_done", sb.size(), 0);
    endtask

    // FIFO memory with a combinational read port
    always_comb bus.mem_data = mem[bus.b_rptr[8:0]];

    // Write pointer as seen two rclk edges later through the synchronizer
    always @(posedge rclk or posedge rst) begin
        if (rst) begin
            wp_d1 <= '0;
            wp_d2 <= '0;
        end else begin
            wp_d1 <= wr_ptr;
            wp_d2 <= wp_d1;
        end
    end

    // Monitor: state checks against the model, then the handshake for the next edge
    always @(negedge rclk) begin
        if (mon_en && !rst) begin
            rd_exp = 10'(rd_base + 10'(n_xfer) + {9'b0, bus.pix_valid});
            check("b_rptr", bus.b_rptr, rd_exp);
            check("g_rptr", bus.g_rptr, bin2gray(rd_exp));
            check("empty", bus.empty, (wp_d2 == rd_exp));
            check("rd_level", bus.rd_level, 10'(wp_d2 - rd_exp));
            check("underflow_cnt", bus.underflow_cnt, uf_model);
            if (prev_b == 10'd1023 && bus.b_rptr == 10'd0) saw_wrap = 1'b1;
            prev_b = bus.b_rptr;
            if (bus.pix_valid && bus.pix_ready && !bus.flush) begin
                if (sb.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL pix_unexpected: got 0x%0h, expected no transfer", bus.pix_data);
                end else begin
                    check("pix_data", bus.pix_data, sb.pop_front());
                end
                n_xfer++;
            end
            if (bus.pix_ready && !bus.pix_valid && uf_model != 16'hFFFF) uf_model++;
        end
    end

    initial begin
        logic [DW-1:0] hold_data;
        logic [9:0]    hold_b;
        logic [15:0]   base;
        int            xb;
        int            n;

        foreach (mem[i]) mem[i] = '0;
        bus.g_wptr    = '0;
        bus.pix_ready = 1'b0;
        bus.flush     = 1'b0;

        // Reset with the clock stopped
        #1 rst = 1'b1;
        #2;
        check("rst_pix_valid", bus.pix_valid, 0);
        check("rst_b_rptr", bus.b_rptr, 0);
        check("rst_g_rptr", bus.g_rptr, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_rd_level", bus.rd_level, 0);
        check("rst_uf_cnt", bus.underflow_cnt, 0);
        clk_en = 1'b1;
        repeat (3) @(posedge rclk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Single-word latency
        @(posedge rclk); #1;
        push_word(4'hA);
        @(posedge rclk); #1;
        check("lat_n_empty", bus.empty, 1);
        @(posedge rclk); #1;
        check("lat_n1_empty", bus.empty, 0);
        check("lat_n1_valid", bus.pix_valid, 0);
        @(posedge rclk); #1;
        check("lat_n2_valid", bus.pix_valid, 1);
        check("lat_n2_data", bus.pix_data, 4'hA);
        check("lat_n2_b_rptr", bus.b_rptr, 1);
        check("lat_n2_rd_level", bus.rd_level, 0);
        check("lat_n2_empty", bus.empty, 1);
        bus.pix_ready = 1'b1;
        @(posedge rclk); #1;
        bus.pix_ready = 1'b0;

        // Streaming 1..8 at full throughput
        for (int i = 1; i <= 8; i++) begin
            @(posedge rclk); #1;
            push_word(4'(i));
        end
        repeat (5) @(posedge rclk);
        #1;
        check("stream_first_valid", bus.pix_valid, 1);
        check("stream_first_data", bus.pix_data, 1);
        check("stream_level", bus.rd_level, 7);
        bus.pix_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge rclk);
            check("stream_valid", bus.pix_valid, 1);
        end
        @(posedge rclk); #1;
        bus.pix_ready = 1'b0;
        check("stream_end_valid", bus.pix_valid, 0);

        // Streaming with a 3-cycle stall
        for (int i = 9; i <= 16; i++) begin
            @(posedge rclk); #1;
            push_word(4'(i));
        end
        repeat (5) @(posedge rclk);
        #1 bus.pix_ready = 1'b1;
        repeat (3) @(posedge rclk);
        #1 bus.pix_ready = 1'b0;
        hold_data = sb[0];
        hold_b    = 10'(rd_base + 10'(n_xfer) + 10'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge rclk);
            check("stall_valid", bus.pix_valid, 1);
            check("stall_data", bus.pix_data, hold_data);
            check("stall_b_rptr", bus.b_rptr, hold_b);
        end
        @(posedge rclk); #1;
        drain();

        // Underflow on an empty FIFO for 5 cycles
        repeat (2) @(posedge rclk);
        #1 base = uf_model;
        check("uf_base", bus.underflow_cnt, base);
        bus.pix_ready = 1'b1;
        repeat (5) @(posedge rclk);
        #1 bus.pix_ready = 1'b0;
        check("uf_plus5", bus.underflow_cnt, 16'(base + 16'd5));

        // Randomized wrap-around run of 1100 words
        n = 0;
        for (int cyc = 0; cyc < 20000 && (n < 1100 || sb.size() != 0); cyc++) begin
            @(posedge rclk); #1;
            bus.pix_ready = ($urandom_range(3) != 0);
            if (n < 1100 && sb.size() < 512 && $urandom_range(3) != 0) begin
                push_word(4'($urandom));
                n++;
            end
        end
        bus.pix_ready = 1'b0;
        check("wrap_all_read", sb.size(), 0);
        check("wrap_written", n, 1100);
        check("wrap_seen", saw_wrap, 1);

        // Flush with rd_level=6 and a pixel waiting
        for (int i = 0; i < 7; i++) begin
            @(posedge rclk); #1;
            push_word(4'($urandom));
        end
        repeat (5) @(posedge rclk);
        #1;
        check("flush_pre_valid", bus.pix_valid, 1);
        check("flush_pre_level", bus.rd_level, 6);
        xb = n_xfer;
        bus.flush     = 1'b1;
        bus.pix_ready = 1'b1;
        @(posedge rclk); #1;
        bus.flush     = 1'b0;
        bus.pix_ready = 1'b0;
        sb.delete();
        rd_base = 10'(wr_ptr - 10'(n_xfer));
        check("flush_no_xfer", n_xfer, xb);
        check("flush_valid", bus.pix_valid, 0);
        check("flush_b_rptr", bus.b_rptr, wr_ptr);
        check("flush_empty", bus.empty, 1);
        check("flush_level", bus.rd_level, 0);

        // Underflow saturation
        bus.pix_ready = 1'b1;
        for (int i = 0; i < 70000 && uf_model != 16'hFFFE; i++) @(posedge rclk);
        #1 bus.pix_ready = 1'b0;
        check("uf_fffe", bus.underflow_cnt, 16'hFFFE);
        bus.pix_ready = 1'b1;
        repeat (4) @(posedge rclk);
        #1 bus.pix_ready = 1'b0;
        check("uf_sat", bus.underflow_cnt, 16'hFFFF);

        // Reset in the middle of operation, away from the clock edge
        for (int i = 0; i < 3; i++) begin
            @(posedge rclk); #1;
            push_word(4'($urandom));
        end
        repeat (5) @(posedge rclk);
        #1;
        check("midrst_pre_valid", bus.pix_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("midrst_valid", bus.pix_valid, 0);
        check("midrst_b_rptr", bus.b_rptr, 0);
        check("midrst_g_rptr", bus.g_rptr, 0);
        check("midrst_uf_cnt", bus.underflow_cnt, 0);
        check("midrst_empty", bus.empty, 1);
        sb.delete();
        wr_ptr     = '0;
        bus.g_wptr = '0;
        rd_base    = '0;
        n_xfer     = 0;
        uf_model   = '0;
        prev_b     = '0;
        repeat (2) @(posedge rclk);
        #1 rst = 1'b0;
        repeat (4) @(posedge rclk);
        #1;
        check("post_rst_empty", bus.empty, 1);
        check("post_rst_valid", bus.pix_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
